// File: rtl/pipeline_dump_serializer.sv
// Snapshots the pipeline segment/control registers on request and streams them
// as a UART frame: header 0xA5, payload bytes MSB first, then XOR checksum.
module pipeline_dump_serializer #(
    parameter int unsigned NB_DATA    = 8,
    parameter int unsigned NB_ID_EX   = 144,
    parameter int unsigned NB_EX_MEM  = 32,
    parameter int unsigned NB_MEM_WB  = 48,
    parameter int unsigned NB_WB_ID   = 40,
    parameter int unsigned NB_CONTROL = 24
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_dump_req,
    input  logic [NB_ID_EX-1:0]   i_segment_registers_ID_EX,
    input  logic [NB_EX_MEM-1:0]  i_segment_registers_EX_MEM,
    input  logic [NB_MEM_WB-1:0]  i_segment_registers_MEM_WB,
    input  logic [NB_WB_ID-1:0]   i_segment_registers_WB_ID,
    input  logic [NB_CONTROL-1:0] i_control_registers_ID_EX,
    input  logic                  i_txDone,
    output logic                  o_tx_start,
    output logic [NB_DATA-1:0]    o_data,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned NB_PAYLOAD = NB_ID_EX + NB_EX_MEM + NB_MEM_WB + NB_WB_ID + NB_CONTROL;
    localparam int unsigned NB_BYTES   = NB_PAYLOAD / NB_DATA;
    localparam int unsigned IDX_W      = $clog2(NB_BYTES + 2);
    localparam int unsigned PB_W       = $clog2(NB_BYTES);

    // Frame index: 0 = header, 1..NB_BYTES = payload, NB_BYTES+1 = checksum.
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NB_BYTES + 1);
    localparam logic [IDX_W-1:0]   PAY_LAST = IDX_W'(NB_BYTES);
    localparam logic [NB_DATA-1:0] HEADER   = NB_DATA'(8'hA5);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        DONE
    } state_t;

    state_t                  state, state_n;
    logic [IDX_W-1:0]        idx, idx_n;
    logic [NB_DATA-1:0]      csum, csum_n;
    logic [NB_PAYLOAD-1:0]   shadow, shadow_n;
    logic                    tx_start_n, busy_n, done_n;
    logic [NB_DATA-1:0]      data_n;

    logic [NB_DATA-1:0]      payload_bytes [NB_BYTES];
    logic [NB_DATA-1:0]      sent_byte;
    logic [NB_DATA-1:0]      csum_upd;
    logic [NB_DATA-1:0]      next_byte;

    // Byte view of the shadow register, element 0 is the most significant byte.
    for (genvar g = 0; g < NB_BYTES; g++) begin : g_bytes
        assign payload_bytes[g] = shadow[NB_PAYLOAD-1-g*NB_DATA -: NB_DATA];
    end

    always_comb begin
        sent_byte = '0;
        if (idx != '0 && idx <= PAY_LAST) begin
            sent_byte = payload_bytes[PB_W'(idx - IDX_W'(1))];
        end
        csum_upd  = csum ^ sent_byte;
        // The byte following the last payload byte is the updated checksum.
        next_byte = (idx < PAY_LAST) ? payload_bytes[PB_W'(idx)] : csum_upd;
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        csum_n     = csum;
        shadow_n   = shadow;
        tx_start_n = 1'b0;
        done_n     = 1'b0;
        busy_n     = o_busy;
        data_n     = o_data;

        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (i_dump_req) begin
                    shadow_n   = {i_segment_registers_ID_EX, i_segment_registers_EX_MEM,
                                  i_segment_registers_MEM_WB, i_segment_registers_WB_ID,
                                  i_control_registers_ID_EX};
                    idx_n      = '0;
                    csum_n     = '0;
                    state_n    = SEND;
                    tx_start_n = 1'b1;
                    data_n     = HEADER;
                    busy_n     = 1'b1;
                end
            end
            SEND: begin
                busy_n  = 1'b1;
                state_n = WAIT;
            end
            WAIT: begin
                busy_n = 1'b1;
                if (i_txDone) begin
                    csum_n = csum_upd;
                    if (idx == LAST_IDX) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        idx_n      = idx + IDX_W'(1);
                        state_n    = SEND;
                        tx_start_n = 1'b1;
                        data_n     = next_byte;
                    end
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            idx        <= '0;
            csum       <= '0;
            shadow     <= '0;
            o_tx_start <= 1'b0;
            o_data     <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            csum       <= csum_n;
            shadow     <= shadow_n;
            o_tx_start <= tx_start_n;
            o_data     <= data_n;
            o_busy     <= busy_n;
            o_done     <= done_n;
        end
    end

endmodule

// File: tb/tb_pipeline_dump_serializer.sv
// Randomized self-checking bench: UART responder model plus a frame reference
// model built directly from the header/payload/checksum rules.
module tb_pipeline_dump_serializer;

    localparam int unsigned NB_PAYLOAD = 288;
    localparam int unsigned NB_BYTES   = 36;
    localparam int unsigned TX_LAT     = 10;

    logic         clk = 1'b0;
    logic         i_reset;
    logic         i_dump_req;
    logic [143:0] id_ex;
    logic [31:0]  ex_mem;
    logic [47:0]  mem_wb;
    logic [39:0]  wb_id;
    logic [23:0]  ctrl;
    logic         i_txDone;
    logic         o_tx_start;
    logic [7:0]   o_data;
    logic         o_busy;
    logic         o_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_dump_serializer dut (
        .clk                        (clk),
        .i_reset                    (i_reset),
        .i_dump_req                 (i_dump_req),
        .i_segment_registers_ID_EX  (id_ex),
        .i_segment_registers_EX_MEM (ex_mem),
        .i_segment_registers_MEM_WB (mem_wb),
        .i_segment_registers_WB_ID  (wb_id),
        .i_control_registers_ID_EX  (ctrl),
        .i_txDone                   (i_txDone),
        .o_tx_start                 (o_tx_start),
        .o_data                     (o_data),
        .o_busy                     (o_busy),
        .o_done                     (o_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_payload(input logic [NB_PAYLOAD-1:0] p);
        id_ex  = p[287:144];
        ex_mem = p[143:112];
        mem_wb = p[111:64];
        wb_id  = p[63:24];
        ctrl   = p[23:0];
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tx_start"}, 32'(o_tx_start), 32'd0);
        check({tag, "_data"},     32'(o_data),     32'd0);
        check({tag, "_busy"},     32'(o_busy),     32'd0);
        check({tag, "_done"},     32'(o_done),     32'd0);
    endtask

    // Runs one requested frame while acting as the UART transmitter.
    task automatic run_frame(input logic [NB_PAYLOAD-1:0] p, input bit mutate,
                             input bit extra_req, input bit do_reset, input bit spurious);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        logic [7:0] cs;
        logic [7:0] b;
        int cd, done_cnt, post;
        bit finished, aborted;

        exp_q.push_back(8'hA5);
        cs = 8'h00;
        for (int k = 0; k < NB_BYTES; k++) begin
            b = p[NB_PAYLOAD-1-8*k -: 8];
            exp_q.push_back(b);
            cs = cs ^ b;
        end
        exp_q.push_back(cs);

        drive_payload(p);
        if (spurious) begin
            i_txDone = 1'b1;
            step();
            i_txDone = 1'b0;
        end
        i_dump_req = 1'b1;
        step();
        i_dump_req = 1'b0;

        cd = 0; done_cnt = 0; post = 0; finished = 0; aborted = 0;
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            if (cyc == 0) check("start_latency", 32'(o_tx_start), 32'd1);
            i_dump_req = 1'b0;
            if (cd > 0) begin
                cd--;
                i_txDone = (cd == 0);
            end else begin
                i_txDone = 1'b0;
            end
            if (o_tx_start) begin
                got_q.push_back(o_data);
                cd = TX_LAT;
                if (spurious && got_q.size() == 3) i_txDone = 1'b1;
                if (mutate && got_q.size() == 5) drive_payload({NB_PAYLOAD{1'b1}});
            end else if (cd > 0 && got_q.size() > 0) begin
                check("data_stable", 32'(o_data), 32'(got_q[$]));
            end
            if (got_q.size() > 0 && done_cnt == 0) check("busy_in_frame", 32'(o_busy), 32'd1);
            if (extra_req && got_q.size() == 10 && cd == 5) i_dump_req = 1'b1;
            if (o_done) begin
                done_cnt++;
                if (extra_req) i_dump_req = 1'b1;
            end
            if (do_reset && got_q.size() == 20 && cd == 5) begin
                i_reset    = 1'b1;
                i_txDone   = 1'b0;
                i_dump_req = 1'b0;
                #1;
                check_idle_outputs("reset_mid");
                step();
                step();
                i_reset = 1'b0;
                for (int j = 0; j < 20; j++) begin
                    step();
                    check("no_start_after_reset", 32'(o_tx_start), 32'd0);
                    check("idle_busy_after_reset", 32'(o_busy), 32'd0);
                    check("no_done_after_reset", 32'(o_done), 32'd0);
                end
                aborted  = 1;
                finished = 1;
            end
            if (done_cnt > 0) post++;
            if (post == 20) finished = 1;
            if (!finished) step();
        end
        i_txDone   = 1'b0;
        i_dump_req = 1'b0;
        if (!finished) check("frame_timeout", 32'd0, 32'd1);

        if (aborted) begin
            check("aborted_len", 32'(got_q.size()), 32'd20);
            check("aborted_done", 32'(done_cnt), 32'd0);
            for (int k = 0; k < 20 && k < got_q.size(); k++) check("aborted_byte", 32'(got_q[k]), 32'(exp_q[k]));
        end else begin
            check("frame_len", 32'(got_q.size()), 32'(exp_q.size()));
            check("done_count", 32'(done_cnt), 32'd1);
            check("busy_after_done", 32'(o_busy), 32'd0);
            for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) check("frame_byte", 32'(got_q[k]), 32'(exp_q[k]));
        end
    endtask

    function automatic logic [NB_PAYLOAD-1:0] rand_payload();
        logic [NB_PAYLOAD-1:0] p;
        for (int k = 0; k < NB_PAYLOAD / 32; k++) p[32*k +: 32] = $urandom;
        return p;
    endfunction

    initial begin
        logic [NB_PAYLOAD-1:0] p;

        i_reset    = 1'b1;
        i_dump_req = 1'b0;
        i_txDone   = 1'b0;
        drive_payload('0);
        step();
        step();
        check_idle_outputs("reset_state");
        i_reset = 1'b0;
        step();
        check_idle_outputs("post_reset_idle");

        // Directed frame: payload bytes 0x01..0x24.
        for (int k = 0; k < NB_BYTES; k++) p[NB_PAYLOAD-1-8*k -: 8] = 8'(k + 1);
        run_frame(p, 0, 0, 0, 0);

        run_frame('0, 0, 0, 0, 0);
        run_frame(rand_payload(), 1, 0, 0, 0);
        run_frame(rand_payload(), 0, 1, 0, 0);
        run_frame(rand_payload(), 0, 0, 1, 0);
        run_frame(rand_payload(), 0, 0, 0, 0);
        run_frame(rand_payload(), 0, 0, 0, 1);
        for (int r = 0; r < 3; r++) run_frame(rand_payload(), 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
